// File: rtl/mem_fetch_buffer_if.sv
// Consumer-side ready/valid stream of mem_fetch_buffer.
// The buffer drives data/last/valid; the consumer drives ready.
interface mem_fetch_buffer_if #(
   parameter int DATA_W = 8
);
   logic [DATA_W-1:0] out_data;
   logic              out_last;
   logic              out_valid;
   logic              out_ready;

   modport master (
      output out_data,
      output out_last,
      output out_valid,
      input  out_ready
   );

   modport slave (
      input  out_data,
      input  out_last,
      input  out_valid,
      output out_ready
   );
endinterface

// File: rtl/mem_fetch_buffer.sv
// Fetches words for generator addresses from a 1-cycle RAM,
// tags the frame's final word and queues them in a FWFT FIFO.
module mem_fetch_buffer #(
   parameter int DATA_W     = 8,
   parameter int ADDR_W     = 5,
   parameter int MAX_ADDR   = 20,
   parameter int FIFO_DEPTH = 8,
   parameter int FIFO_AW    = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] addr_in,
   input  logic              nd_in,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rd_en,
   input  logic [DATA_W-1:0] mem_rdata,
   mem_fetch_buffer_if.master out,
   output logic              stall,
   output logic              overflow,
   output logic              addr_err,
   output logic [7:0]        frame_count
);

   localparam int CW = FIFO_AW + 1;
   localparam logic [ADDR_W-1:0] MAX_A = ADDR_W'(MAX_ADDR);
   localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
   localparam logic [CW-1:0] STALL_C = CW'(FIFO_DEPTH - 2);
   localparam logic [CW-1:0] CNT_ONE = CW'(1);
   localparam logic [FIFO_AW-1:0] PTR_ONE = FIFO_AW'(1);

   logic              p1_valid;
   logic              p1_last;
   logic              p2_valid;
   logic              p2_last;
   logic              addr_ok;

   logic [DATA_W:0]   fifo_mem [FIFO_DEPTH];
   logic [DATA_W:0]   head;
   logic [FIFO_AW-1:0] wr_ptr;
   logic [FIFO_AW-1:0] rd_ptr;
   logic [CW-1:0]     count;
   logic [CW-1:0]     count_next;
   logic              full;
   logic              push;
   logic              push_ok;
   logic              pop;
   logic              drop;
   logic              valid_i;

   assign addr_ok = (addr_in <= MAX_A);

   // Request stage: register the RAM read and flag illegal addresses.
   always_ff @(posedge clk) begin
      if (reset) begin
         mem_addr  <= '0;
         mem_rd_en <= 1'b0;
         p1_valid  <= 1'b0;
         p1_last   <= 1'b0;
         addr_err  <= 1'b0;
      end else if (nd_in) begin
         if (addr_ok) begin
            mem_addr  <= addr_in;
            mem_rd_en <= 1'b1;
            p1_valid  <= 1'b1;
            p1_last   <= (addr_in == MAX_A);
         end else begin
            mem_rd_en <= 1'b0;
            p1_valid  <= 1'b0;
            addr_err  <= 1'b1;
         end
      end else begin
         mem_rd_en <= 1'b0;
         p1_valid  <= 1'b0;
      end
   end

   // Track each read until its data appears on mem_rdata.
   always_ff @(posedge clk) begin
      if (reset) begin
         p2_valid <= 1'b0;
         p2_last  <= 1'b0;
      end else begin
         p2_valid <= p1_valid;
         p2_last  <= p1_last;
      end
   end

   // FIFO control: a push into a full FIFO is allowed only with a pop.
   always_comb begin
      valid_i    = (count != '0);
      full       = (count == DEPTH_C);
      push       = p2_valid;
      pop        = valid_i & out.out_ready;
      push_ok    = push & (~full | pop);
      drop       = push & full & ~pop;
      count_next = count;
      unique case ({push_ok, pop})
         2'b10:   count_next = count + CNT_ONE;
         2'b01:   count_next = count - CNT_ONE;
         default: count_next = count;
      endcase
   end

   // Storage holds {data, last}; no reset, the count gates visibility.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         fifo_mem[wr_ptr] <= {mem_rdata, p2_last};
      end
   end

   // Pointers, occupancy and the status flags derived from them.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         count       <= '0;
         stall       <= 1'b0;
         overflow    <= 1'b0;
         frame_count <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr <= wr_ptr + PTR_ONE;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PTR_ONE;
            if (head[0]) begin
               frame_count <= frame_count + 8'd1;
            end
         end
         if (drop) begin
            overflow <= 1'b1;
         end
         count <= count_next;
         stall <= (count_next >= STALL_C);
      end
   end

   // Head entry falls through; outputs read zero while empty.
   always_comb begin
      head          = fifo_mem[rd_ptr];
      out.out_valid = valid_i;
      out.out_data  = valid_i ? head[DATA_W:1] : '0;
      out.out_last  = valid_i & head[0];
   end

endmodule

// File: tb/tb_mem_fetch_buffer.sv
// Directed bench for mem_fetch_buffer with a 1-cycle RAM model.
// Table-driven stream check plus hand-written corner sequences.
module tb_mem_fetch_buffer;

   logic       clk = 1'b0;
   logic       reset;
   logic [4:0] addr_in;
   logic       nd_in;
   logic [4:0] mem_addr;
   logic       mem_rd_en;
   logic [7:0] mem_rdata;
   logic       stall;
   logic       overflow;
   logic       addr_err;
   logic [7:0] frame_count;

   int tests = 0;
   int fails = 0;

   mem_fetch_buffer_if #(.DATA_W(8)) bus ();

   mem_fetch_buffer #(
      .DATA_W(8), .ADDR_W(5), .MAX_ADDR(20),
      .FIFO_DEPTH(8), .FIFO_AW(3)
   ) dut (
      .clk(clk),
      .reset(reset),
      .addr_in(addr_in),
      .nd_in(nd_in),
      .mem_addr(mem_addr),
      .mem_rd_en(mem_rd_en),
      .mem_rdata(mem_rdata),
      .out(bus),
      .stall(stall),
      .overflow(overflow),
      .addr_err(addr_err),
      .frame_count(frame_count)
   );

   always #5 clk = ~clk;

   // RAM model: RAM[a] = a + 8'h10, one cycle read latency.
   always @(posedge clk) begin
      if (mem_rd_en) mem_rdata <= {3'b000, mem_addr} + 8'h10;
   end

   // Collect popped words, sampled mid-cycle.
   logic [8:0] got [$];
   bit mon_en = 1'b0;
   always @(negedge clk) begin
      if (mon_en && bus.out_valid && bus.out_ready)
         got.push_back({bus.out_last, bus.out_data});
   end

   typedef struct {
      logic       nd;
      logic [4:0] addr;
      logic       ready;
      logic       exp_rd;
      logic       exp_valid;
      logic [7:0] exp_data;
      logic       exp_last;
   } vec_t;

   vec_t tbl [23];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name,
                        input logic [31:0] act,
                        input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      reset = 1'b1;
      nd_in = 1'b0;
      addr_in = '0;
      bus.out_ready = 1'b0;
      step();
      reset = 1'b0;
   endtask

   task automatic check_reset_vals(input string tag);
      check({tag, " mem_addr"}, 32'(mem_addr), 0);
      check({tag, " mem_rd_en"}, 32'(mem_rd_en), 0);
      check({tag, " out_valid"}, 32'(bus.out_valid), 0);
      check({tag, " out_last"}, 32'(bus.out_last), 0);
      check({tag, " out_data"}, 32'(bus.out_data), 0);
      check({tag, " stall"}, 32'(stall), 0);
      check({tag, " overflow"}, 32'(overflow), 0);
      check({tag, " addr_err"}, 32'(addr_err), 0);
      check({tag, " frame_count"}, 32'(frame_count), 0);
   endtask

   task automatic run_frames(input int n);
      for (int f = 0; f < n; f++) begin
         for (int a = 0; a <= 20; a++) begin
            nd_in = 1'b1;
            addr_in = 5'(a);
            step();
         end
      end
      nd_in = 1'b0;
      repeat (5) step();
   endtask

   initial begin
      reset = 1'b1;
      nd_in = 1'b0;
      addr_in = '0;
      bus.out_ready = 1'b0;

      // Reset values.
      do_reset();
      check_reset_vals("init");

      // Stream 0..20, consumer always ready.
      for (int i = 0; i < 23; i++) begin
         tbl[i].nd        = (i <= 20);
         tbl[i].addr      = (i <= 20) ? 5'(i) : 5'd0;
         tbl[i].ready     = 1'b1;
         tbl[i].exp_rd    = (i <= 20);
         tbl[i].exp_valid = (i >= 2);
         tbl[i].exp_data  = (i >= 2) ? 8'(i - 2 + 16) : 8'h00;
         tbl[i].exp_last  = (i == 22);
      end
      for (int i = 0; i < 23; i++) begin
         nd_in = tbl[i].nd;
         addr_in = tbl[i].addr;
         bus.out_ready = tbl[i].ready;
         step();
         check($sformatf("s1 rd_en[%0d]", i),
               32'(mem_rd_en), 32'(tbl[i].exp_rd));
         if (tbl[i].nd)
            check($sformatf("s1 mem_addr[%0d]", i),
                  32'(mem_addr), 32'(tbl[i].addr));
         check($sformatf("s1 valid[%0d]", i),
               32'(bus.out_valid), 32'(tbl[i].exp_valid));
         if (tbl[i].exp_valid) begin
            check($sformatf("s1 data[%0d]", i),
                  32'(bus.out_data), 32'(tbl[i].exp_data));
            check($sformatf("s1 last[%0d]", i),
                  32'(bus.out_last), 32'(tbl[i].exp_last));
         end
      end
      nd_in = 1'b0;
      step();
      check("s1 frame_count", 32'(frame_count), 1);
      check("s1 overflow", 32'(overflow), 0);
      check("s1 empty", 32'(bus.out_valid), 0);

      // Same stream, consumer stalled: fill, stall, overflow.
      do_reset();
      got.delete();
      mon_en = 1'b1;
      for (int i = 0; i < 23; i++) begin
         nd_in = (i <= 20);
         addr_in = (i <= 20) ? 5'(i) : 5'd0;
         step();
         if (i == 6) check("s2 stall@5", 32'(stall), 0);
         if (i == 7) check("s2 stall@6", 32'(stall), 1);
         if (i == 9) check("s2 ovf before", 32'(overflow), 0);
         if (i == 10) check("s2 ovf after", 32'(overflow), 1);
      end
      check("s2 head", 32'(bus.out_data), 32'h10);
      nd_in = 1'b0;
      bus.out_ready = 1'b1;
      repeat (12) step();
      check("s2 pop count", 32'(got.size()), 8);
      for (int k = 0; k < got.size() && k < 8; k++)
         check($sformatf("s2 pop[%0d]", k),
               32'(got[k]), 32'(9'(k + 16)));
      check("s2 frame_count", 32'(frame_count), 0);
      check("s2 ovf sticky", 32'(overflow), 1);
      check("s2 stall low", 32'(stall), 0);

      // Full FIFO with push and pop together every cycle.
      do_reset();
      got.delete();
      for (int i = 0; i < 20; i++) begin
         nd_in = 1'b1;
         addr_in = 5'(i);
         bus.out_ready = (i >= 10);
         step();
         if (i >= 10)
            check($sformatf("s3 stall[%0d]", i), 32'(stall), 1);
      end
      nd_in = 1'b0;
      repeat (12) step();
      check("s3 overflow", 32'(overflow), 0);
      check("s3 pop count", 32'(got.size()), 20);
      for (int k = 0; k < got.size() && k < 20; k++)
         check($sformatf("s3 pop[%0d]", k),
               32'(got[k]), 32'(9'(k + 16)));
      mon_en = 1'b0;

      // Illegal address, then a legal one.
      do_reset();
      nd_in = 1'b1;
      addr_in = 5'd25;
      step();
      check("s4 rd_en", 32'(mem_rd_en), 0);
      check("s4 addr_err", 32'(addr_err), 1);
      addr_in = 5'd3;
      step();
      check("s4 rd_en 3", 32'(mem_rd_en), 1);
      check("s4 mem_addr 3", 32'(mem_addr), 3);
      check("s4 fifo empty", 32'(bus.out_valid), 0);
      nd_in = 1'b0;
      step();
      check("s4 fifo empty2", 32'(bus.out_valid), 0);
      step();
      check("s4 valid", 32'(bus.out_valid), 1);
      check("s4 data", 32'(bus.out_data), 32'h13);
      check("s4 err sticky", 32'(addr_err), 1);

      // Reset while a read at address 5 is in flight.
      nd_in = 1'b1;
      addr_in = 5'd5;
      step();
      reset = 1'b1;
      nd_in = 1'b0;
      step();
      check_reset_vals("s5");
      reset = 1'b0;
      step();
      check("s5 no stale 1", 32'(bus.out_valid), 0);
      step();
      check("s5 no stale 2", 32'(bus.out_valid), 0);
      nd_in = 1'b1;
      addr_in = 5'd20;
      step();
      nd_in = 1'b0;
      step();
      step();
      check("s5 new valid", 32'(bus.out_valid), 1);
      check("s5 new data", 32'(bus.out_data), 32'h24);
      check("s5 new last", 32'(bus.out_last), 1);

      // frame_count wrap.
      do_reset();
      bus.out_ready = 1'b1;
      run_frames(128);
      check("s6 fc 128", 32'(frame_count), 128);
      run_frames(128);
      check("s6 fc 256", 32'(frame_count), 0);
      run_frames(1);
      check("s6 fc 257", 32'(frame_count), 1);
      check("s6 overflow", 32'(overflow), 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/mem_fetch_buffer.md
Name: mem_fetch_buffer

Overview:
- Sits directly downstream of the address generator and consumes its `address`/`nd` stream.
- For every sampled request, issues a read to a 1-cycle-latency synchronous RAM.
- Captures the returned word, tags the word at the frame's final address as `last`, and queues it in an internal FIFO.
- The FIFO drains to a ready/valid consumer; the block also reports almost-full, overflow, address errors and completed-frame count.

Parameters:
- DATA_W, 8, RAM data width and `out_data` width.
- ADDR_W, 5, address width; must match the generator's bitwidth.
- MAX_ADDR, 20, final address of a frame; sets `last`; addresses above it are illegal.
- FIFO_DEPTH, 8, number of FIFO entries; must be a power of two, ≥4.
- FIFO_AW, 3, log2(FIFO_DEPTH).

Ports:
- clk, input, 1, rising-edge clock.
- reset, input, 1, synchronous, active-high.
- addr_in, input, ADDR_W, request address from the generator.
- nd_in, input, 1, request strobe; each rising edge that samples it high is one request.
- mem_addr, output, ADDR_W, registered RAM read address.
- mem_rd_en, output, 1, registered RAM read enable.
- mem_rdata, input, DATA_W, RAM read data, valid one cycle after mem_rd_en.
- out_data, output, DATA_W, FIFO head data.
- out_last, output, 1, FIFO head is the MAX_ADDR word.
- out_valid, output, 1, FIFO non-empty.
- out_ready, input, 1, consumer accepts head.
- stall, output, 1, almost-full advisory to the upstream.
- overflow, output, 1, sticky; a word was dropped.
- addr_err, output, 1, sticky; a request with addr_in > MAX_ADDR was seen.
- frame_count, output, 8, number of `last` words popped, modulo 256.

Behaviour:
- **Reset** (sampled high at a rising edge) clears all of the following, regardless of what is in flight:
  - Outputs: mem_addr=0, mem_rd_en=0, out_valid=0, out_last=0, out_data=0, stall=0, overflow=0, addr_err=0, frame_count=0.
  - FIFO pointers and count go to 0.
  - Pipeline valid/last flags are cleared.
  - Any RAM data returning on the cycle after reset is discarded.
- **Stage 0, request.** At an edge with nd_in=1:
  - If addr_in ≤ MAX_ADDR: mem_addr<=addr_in, mem_rd_en<=1, p1_valid<=1, p1_last<=(addr_in==MAX_ADDR).
  - If addr_in > MAX_ADDR: no read, mem_rd_en<=0, addr_err<=1 (sticky).
  - If nd_in=0: mem_rd_en<=0, p1_valid<=0, and mem_addr holds its value.
- **Stage 1, capture.** While p1_valid=1, at the next edge a FIFO push is attempted with {mem_rdata, p1_last}.
- **Latency.**
  - nd_in sampled at edge k → mem_rd_en high during k..k+1 → word in FIFO and out_valid=1 after edge k+2 (FIFO previously empty).
  - Sustained throughput is one word per clock.
- **FIFO.**
  - out_data and out_last are driven from the head entry (registered or first-word-fall-through memory; head visible whenever out_valid=1).
  - A pop occurs when out_valid & out_ready.
  - Push and pop in the same cycle: count is unchanged and both operations succeed, including when the FIFO is full.
  - Push when count==FIFO_DEPTH with no pop: the word is dropped, overflow<=1 (sticky until reset), and count, pointers and contents are unchanged.
  - Pop when empty: impossible by definition (out_valid=0); out_ready is ignored.
  - Pointers wrap modulo FIFO_DEPTH.
- **stall.**
  - Registered: stall = (count_next ≥ FIFO_DEPTH-2). The margin covers the two words already in the pipeline.
  - Advisory only; the block does not gate nd_in on it.
- **frame_count.** Increments by 1 on each pop whose out_last=1; wraps 255→0.
- **Wrap-around.** The generator's MAX_ADDR→0 sequence produces consecutive frames with no gap. `last` marks only the word fetched from MAX_ADDR.
- **Reset mid-frame.** Partial frame data is flushed. After reset the next frame's words are accepted normally; no `last` is synthesised for the partial frame.

Test Plan:
- Reset, then addr_in=0..20 with nd_in=1 every cycle, out_ready=1, RAM[a]=a+8'h10 → out_data 8'h10..8'h24 in order, first word 2 cycles after the first sampling edge. out_last=1 only on 8'h24. frame_count=1 afterwards. overflow=0.
- Same stream with out_ready=0 throughout:
  - stall rises when count reaches 6.
  - FIFO holds 8'h10..8'h17.
  - The 9th word (8'h18) and later are dropped and overflow=1.
  - Raising out_ready then pops exactly 8'h10..8'h17.
- FIFO full (8 entries), with nd_in and out_ready both high for 10 cycles → count stays 8, no overflow, output order is preserved with no skipped words.
- addr_in=25, nd_in=1 for one cycle → mem_rd_en stays 0, addr_err=1, FIFO unchanged; a following addr_in=3 request is fetched normally.
- Reset asserted one cycle after a request at addr 5 (word in flight) → after reset out_valid=0 and all outputs are at reset values. The RAM word returning in the reset-release cycle does not appear.
- 256 full frames with out_ready=1 → frame_count wraps to 0; 257 frames → frame_count=1.
